// File: rtl/byte_loader.sv
// Stream-to-RAM frame loader: parses an address/count header from a byte stream
// and writes the following big-endian 16-bit words to consecutive RAM addresses.
module byte_loader #(
    parameter int unsigned adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    output logic [15:0] mem_a,
    output logic [15:0] mem_do,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        SAddrHi,
        SAddrLo,
        SCntHi,
        SCntLo,
        SDataHi,
        SDataLo,
        SWrite,
        SDone
    } state_e;

    // Even byte addresses inside the RAM window only.
    localparam logic [31:0] AddrSpan = (32'd1 << adr_width) - 32'd1;
    localparam logic [15:0] AddrMask = AddrSpan[15:0] & 16'hFFFE;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] mem_a_q, mem_a_d;
    logic [15:0] mem_do_q, mem_do_d;
    logic [15:0] sum_q, sum_d;
    logic        accept;

    assign in_ready = (state_q != SWrite) && (state_q != SDone);
    assign busy     = (state_q != SAddrHi);
    assign mem_we   = (state_q == SWrite) && !abort;
    assign done     = (state_q == SDone) && !abort;
    assign mem_a    = mem_a_q;
    assign mem_do   = mem_do_q;
    assign checksum = sum_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        mem_a_d  = mem_a_q;
        mem_do_d = mem_do_q;
        sum_d    = sum_q;
        if (abort) begin
            state_d = SAddrHi;
        end else begin
            unique case (state_q)
                SAddrHi: if (accept) begin
                    addr_d  = {in_data, 8'h00};
                    sum_d   = 16'h0000;
                    state_d = SAddrLo;
                end
                SAddrLo: if (accept) begin
                    addr_d  = {addr_q[15:8], in_data} & AddrMask;
                    state_d = SCntHi;
                end
                SCntHi: if (accept) begin
                    cnt_d   = {in_data, 8'h00};
                    state_d = SCntLo;
                end
                SCntLo: if (accept) begin
                    cnt_d   = {cnt_q[15:8], in_data};
                    state_d = ({cnt_q[15:8], in_data} == 16'h0000) ? SDone : SDataHi;
                end
                SDataHi: if (accept) begin
                    hi_d    = in_data;
                    state_d = SDataLo;
                end
                SDataLo: if (accept) begin
                    mem_do_d = {hi_q, in_data};
                    mem_a_d  = addr_q;
                    state_d  = SWrite;
                end
                SWrite: begin
                    cnt_d   = cnt_q - 16'd1;
                    addr_d  = (addr_q + 16'd2) & AddrMask;
                    sum_d   = sum_q + mem_do_q;
                    state_d = (cnt_q == 16'd1) ? SDone : SDataHi;
                end
                SDone: state_d = SAddrHi;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= SAddrHi;
            addr_q   <= 16'h0000;
            cnt_q    <= 16'h0000;
            hi_q     <= 8'h00;
            mem_a_q  <= 16'h0000;
            mem_do_q <= 16'h0000;
            sum_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            mem_a_q  <= mem_a_d;
            mem_do_q <= mem_do_d;
            sum_q    <= sum_d;
        end
    end

endmodule
